// File: rtl/product_accumulator_if.sv
// Stream bundle for product_accumulator: product input stream (with block
// length config) and the block-result output stream.
//   slave  - the accumulator side
//   master - the upstream/downstream environment side
interface product_accumulator_if #(
  parameter int IN_W  = 64,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_product;
  logic [CNT_W-1:0] cfg_len;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_product, cfg_len, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_product, cfg_len, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a block of cfg_len unsigned products (0 means
// 2**CNT_W) into an ACC_W-bit result presented on a valid/ready output.
// A new block may start in the same cycle the previous result is taken, so
// blocks stream back to back with no bubble.
// Optional feature macro: ACC_SAT_EN -- when defined, the sum clamps to
// 2**ACC_W-1 on overflow for the rest of the block; otherwise it wraps.
// out_ovf reports overflow in both builds.
module product_accumulator #(
  parameter int IN_W  = 64,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W:0] MAX_LEN = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE     = {{CNT_W{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W:0]   cnt;      // one extra bit so a full 2**CNT_W block is countable
  logic [CNT_W:0]   len_q;
  logic [CNT_W:0]   len_eff;
  logic [CNT_W:0]   cnt_inc;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic             ovf;
  logic             beat;
  logic             start;
  logic             acc_beat;

  assign beat     = bus.in_valid && bus.in_ready;
  // A beat outside ACC always opens a new block (in DONE it coincides with
  // the result handshake because in_ready follows out_ready there).
  assign start    = beat && (state != ACC);
  assign acc_beat = beat && (state == ACC);
  assign len_eff  = (bus.cfg_len == '0) ? MAX_LEN : {1'b0, bus.cfg_len};
  assign cnt_inc  = cnt + ONE;
  assign sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(bus.in_product);
  assign carry    = sum_wide[ACC_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len_eff == ONE) ? DONE : ACC;
      ACC:  if (acc_beat && (cnt_inc == len_q)) state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (start) state_nxt = (len_eff == ONE) ? DONE : ACC;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    bus.in_ready = 1'b1;
        ACC:     bus.in_ready = 1'b1;
        DONE: begin
          bus.in_ready  = bus.out_ready;
          bus.out_valid = 1'b1;
        end
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  // Accumulator update for a mid-block beat: wrap or clamp on carry-out.
  always_comb begin
`ifdef ACC_SAT_EN
    if (carry || ovf) acc_nxt = '1;
    else              acc_nxt = sum_wide[ACC_W-1:0];
`else
    acc_nxt = sum_wide[ACC_W-1:0];
`endif
  end

  // Block datapath: first beat loads, later beats accumulate; held in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (start) begin
      acc   <= ACC_W'(bus.in_product);
      cnt   <= ONE;
      len_q <= len_eff;
      ovf   <= 1'b0;
    end else if (acc_beat) begin
      acc   <= acc_nxt;
      cnt   <= cnt_inc;
      ovf   <= ovf | carry;
    end
  end

  assign bus.out_sum   = acc;
  assign bus.out_count = cnt[CNT_W-1:0];
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a 72-bit-accumulator instance
// for the main scenarios and a 64-bit-accumulator instance for overflow.
// Expected block results are queued when stimulus is driven and compared
// when the DUT completes a result handshake.
module tb_product_accumulator;

  typedef struct {
    logic [71:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  product_accumulator_if #(.IN_W(64), .ACC_W(72), .CNT_W(8)) ifa ();
  product_accumulator_if #(.IN_W(64), .ACC_W(64), .CNT_W(8)) ifb ();

  product_accumulator #(.IN_W(64), .ACC_W(72), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  product_accumulator #(.IN_W(64), .ACC_W(64), .CNT_W(8)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [71:0] s, input logic [7:0] c, input logic o);
    exp_t e;
    e.sum = s; e.count = c; e.ovf = o;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [71:0] s, input logic [7:0] c, input logic o);
    exp_t e;
    e.sum = s; e.count = c; e.ovf = o;
    qb.push_back(e);
  endtask

  // One clock: score any result handshake at the negedge, then advance to
  // just after the next rising edge where the main thread drives inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (ifa.out_valid && ifa.out_ready) begin
      check("a_result_expected", 128'(qa.size() != 0), 128'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_sum",   128'(ifa.out_sum),   128'(e.sum));
        check("a_count", 128'(ifa.out_count), 128'(e.count));
        check("a_ovf",   128'(ifa.out_ovf),   128'(e.ovf));
      end
    end
    if (ifb.out_valid && ifb.out_ready) begin
      check("b_result_expected", 128'(qb.size() != 0), 128'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_sum",   128'(ifb.out_sum[63:0]), 128'(e.sum));
        check("b_count", 128'(ifb.out_count),     128'(e.count));
        check("b_ovf",   128'(ifb.out_ovf),       128'(e.ovf));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [63:0] p, input logic [7:0] len);
    ifa.in_valid   = 1'b1;
    ifa.in_product = p;
    ifa.cfg_len    = len;
    cycle();
    ifa.in_valid   = 1'b0;
  endtask

  task automatic beat_b(input logic [63:0] p, input logic [7:0] len);
    ifb.in_valid   = 1'b1;
    ifb.in_product = p;
    ifb.cfg_len    = len;
    cycle();
    ifb.in_valid   = 1'b0;
  endtask

  initial begin
    logic [72:0] model_sum;
    logic [63:0] all_ones;
    logic [63:0] half;
    all_ones = '1;
    half     = 64'h8000_0000_0000_0000;

    ifa.in_valid = 1'b0; ifa.in_product = '0; ifa.cfg_len = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_product = '0; ifb.cfg_len = '0; ifb.out_ready = 1'b1;

    // Reset state
    cycle();
    cycle();
    check("rst_in_ready",  128'(ifa.in_ready),  128'd0);
    check("rst_out_valid", 128'(ifa.out_valid), 128'd0);
    check("rst_out_sum",   128'(ifa.out_sum),   128'd0);
    check("rst_out_count", 128'(ifa.out_count), 128'd0);
    check("rst_out_ovf",   128'(ifa.out_ovf),   128'd0);
    rst = 1'b0;
    cycle();
    check("idle_in_ready", 128'(ifa.in_ready), 128'd1);

    // 1: block of four, 1+2+3+4
    push_a(72'd10, 8'd4, 1'b0);
    beat_a(64'd1, 8'd4);
    beat_a(64'd2, 8'd4);
    beat_a(64'd3, 8'd4);
    check("t1_no_early_valid", 128'(ifa.out_valid), 128'd0);
    beat_a(64'd4, 8'd4);
    check("t1_valid_latency", 128'(ifa.out_valid), 128'd1);
    cycle();
    check("t1_back_to_idle", 128'(ifa.out_valid), 128'd0);

    // 2: single-product blocks every cycle
    ifa.in_valid   = 1'b1;
    ifa.in_product = all_ones;
    ifa.cfg_len    = 8'd1;
    for (int i = 0; i < 6; i++) begin
      push_a(72'(all_ones), 8'd1, 1'b0);
      cycle();
      check("t2_out_valid", 128'(ifa.out_valid), 128'd1);
      check("t2_in_ready",  128'(ifa.in_ready),  128'd1);
    end
    ifa.in_valid = 1'b0;
    cycle();

    // 3: backpressure on the result, then take it with a simultaneous beat
    ifa.out_ready = 1'b0;
    push_a(72'd15, 8'd2, 1'b0);
    beat_a(64'd7, 8'd2);
    beat_a(64'd8, 8'd2);
    for (int i = 0; i < 5; i++) begin
      check("t3_held_valid",   128'(ifa.out_valid), 128'd1);
      check("t3_in_ready_low", 128'(ifa.in_ready),  128'd0);
      check("t3_held_sum",     128'(ifa.out_sum),   128'd15);
      cycle();
    end
    ifa.out_ready  = 1'b1;
    ifa.in_valid   = 1'b1;
    ifa.in_product = 64'd3;
    ifa.cfg_len    = 8'd2;
    #1;
    check("t3_in_ready_follows", 128'(ifa.in_ready), 128'd1);
    push_a(72'd7, 8'd2, 1'b0);
    cycle();
    check("t3_new_block_started", 128'(ifa.out_valid), 128'd0);
    beat_a(64'd4, 8'd2);
    cycle();

    // 4: full 256-product block of all-ones
    model_sum = '0;
    for (int i = 0; i < 256; i++) model_sum = model_sum + 73'(all_ones);
    push_a(model_sum[71:0], 8'd0, model_sum[72]);
    ifa.in_valid   = 1'b1;
    ifa.in_product = all_ones;
    ifa.cfg_len    = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("t4_not_done_early", 128'(ifa.out_valid), 128'd0);
      cycle();
    end
    ifa.in_valid = 1'b0;
    check("t4_done", 128'(ifa.out_valid), 128'd1);
    cycle();

    // 5: 64-bit accumulator overflow
`ifdef ACC_SAT_EN
    push_b(72'(all_ones), 8'd2, 1'b1);
    push_b(72'(all_ones), 8'd3, 1'b1);
`else
    push_b(72'd0, 8'd2, 1'b1);
    push_b(72'd5, 8'd3, 1'b1);
`endif
    beat_b(half, 8'd2);
    beat_b(half, 8'd2);
    cycle();
    beat_b(half, 8'd3);
    beat_b(half, 8'd3);
    beat_b(64'd5, 8'd3);
    cycle();

    // 6: reset mid-block discards the partial sum
    beat_a(64'd9, 8'd4);
    beat_a(64'd9, 8'd4);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 128'(ifa.out_valid), 128'd0);
    check("t6_rst_in_ready",  128'(ifa.in_ready),  128'd0);
    cycle();
    rst = 1'b0;
    cycle();
    push_a(72'd10, 8'd2, 1'b0);
    beat_a(64'd5, 8'd2);
    beat_a(64'd5, 8'd2);
    cycle();
    cycle();

    check("a_queue_drained", 128'(qa.size()), 128'd0);
    check("b_queue_drained", 128'(qb.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
